// File: rtl/alu_seq.sv
// alu_seq -- multi-cycle ALU with an iterative one-bit-per-cycle shifter.
//
// Single-cycle ops (FWD, ADD, AND, OR) complete on the accept edge. Shift and
// rotate ops (SLL, SRL, SRA, ROR) load the operand into a shift register and
// step it one bit per clock until the counter runs out.
//
// Ports:
//   clk_i      clock; all state updates on the rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    operation request, sampled on a rising edge while busy_o=0
//   select_i   opcode: 000 FWD, 001 ADD, 010 AND, 011 OR,
//                      100 SLL, 101 SRL, 110 SRA, 111 ROR
//   data1_i    operand A (value to be shifted for shift/rotate ops)
//   data2_i    operand B (shift amount for shift/rotate ops)
//   busy_o     high while a shift/rotate is iterating
//   done_o     one-cycle pulse: result_o, zero_o and carry_o were just updated
//   result_o   registered result, held until the next completion
//   zero_o     registered, equals ~|result_o
//   carry_o    registered carry-out of ADD, 0 for every other op
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       select_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o
);

  // Counter must be able to hold WIDTH itself (clamped SLL/SRL/SRA count).
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  // Low two opcode bits select the shift flavour once select_i[2] is set.
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;

  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] alu_d;
  logic             alu_carry_d;
  logic [CNT_W-1:0] n_d;
  logic [WIDTH-1:0] step_d;

  // Single-cycle ALU results and the shift count, from the live inputs.
  always_comb begin
    sum_d       = {1'b0, data1_i} + {1'b0, data2_i};
    alu_d       = data2_i;
    alu_carry_d = 1'b0;
    case (select_i[1:0])
      2'b00: alu_d = data2_i;
      2'b01: begin
        alu_d       = sum_d[WIDTH-1:0];
        alu_carry_d = sum_d[WIDTH];
      end
      2'b10: alu_d = data1_i & data2_i;
      2'b11: alu_d = data1_i | data2_i;
      default: alu_d = data2_i;
    endcase

    // ROR wraps the count; the plain shifts saturate at WIDTH, since any
    // larger amount gives the same result as shifting by WIDTH.
    if (select_i[1:0] == OP_ROR) begin
      n_d = {1'b0, data2_i[SH_W-1:0]};
    end else if (data2_i >= WIDTH_V) begin
      n_d = CNT_W'(WIDTH);
    end else begin
      n_d = {1'b0, data2_i[SH_W-1:0]};
    end
  end

  // One-bit step of the latched shift flavour.
  always_comb begin
    step_d = shreg_q;
    case (op_q)
      OP_SLL: step_d = {shreg_q[WIDTH-2:0], 1'b0};
      OP_SRL: step_d = {1'b0, shreg_q[WIDTH-1:1]};
      OP_SRA: step_d = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
      OP_ROR: step_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
      default: step_d = shreg_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      shreg_q  <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (!select_i[2]) begin
              result_q <= alu_d;
              zero_q   <= ~|alu_d;
              carry_q  <= alu_carry_d;
              done_q   <= 1'b1;
            end else begin
              op_q    <= select_i[1:0];
              shreg_q <= data1_i;
              cnt_q   <= n_d;
              if (n_d == '0) begin
                // Zero-length shift completes like a single-cycle op.
                result_q <= data1_i;
                zero_q   <= ~|data1_i;
                carry_q  <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                state_q <= S_SHIFT;
              end
            end
          end
        end
        S_SHIFT: begin
          // start_i is deliberately not looked at here: requests while
          // busy are dropped, not queued.
          shreg_q <= step_d;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q <= step_d;
            zero_q   <= ~|step_d;
            carry_q  <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q == S_SHIFT);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign carry_o  = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- directed, table-driven bench for alu_seq (WIDTH=8), with
// hand-written sequences for back-to-back throughput, mid-shift input
// changes, START while busy and reset in the middle of a shift.
module tb_alu_seq;

  localparam logic [2:0] FWD = 3'b000;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] SLL = 3'b100;
  localparam logic [2:0] SRL = 3'b101;
  localparam logic [2:0] SRA = 3'b110;
  localparam logic [2:0] ROR = 3'b111;
  localparam int MAX_WAIT = 20;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] select;
  logic [7:0] data1;
  logic [7:0] data2;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       zero;
  logic       carry;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .select_i(select),
    .data1_i (data1),
    .data2_i (data2),
    .busy_o  (busy),
    .done_o  (done),
    .result_o(result),
    .zero_o  (zero),
    .carry_o (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one START pulse at the next rising edge, then wait for DONE.
  // lat = cycles after the accept edge at which DONE is seen (MAX_WAIT+1 on
  // timeout); nbusy = cycles with BUSY high before DONE.
  task automatic run_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int nbusy);
    @(negedge clk);
    select = sel;
    data1  = a;
    data2  = b;
    start  = 1'b1;
    @(posedge clk);
    nbusy = 0;
    lat   = MAX_WAIT + 1;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
    int         lat;
    int         nbusy;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int lat;
    int nbusy;
    int ndone;

    vecs[0]  = '{ADD, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1, 0};
    vecs[1]  = '{AND, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1, 0};
    vecs[2]  = '{FWD, 8'h33, 8'h5A, 8'h5A, 1'b0, 1'b0, 1, 0};
    vecs[3]  = '{OR,  8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1, 0};
    vecs[4]  = '{ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1, 0};
    vecs[5]  = '{ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1, 0};
    vecs[6]  = '{SLL, 8'h81, 8'd3,  8'h08, 1'b0, 1'b0, 4, 3};
    vecs[7]  = '{SRA, 8'h90, 8'd9,  8'hFF, 1'b0, 1'b0, 9, 8};
    vecs[8]  = '{SRL, 8'h90, 8'd0,  8'h90, 1'b0, 1'b0, 1, 0};
    vecs[9]  = '{ROR, 8'h01, 8'd10, 8'h40, 1'b0, 1'b0, 3, 2};
    vecs[10] = '{SRL, 8'h80, 8'd7,  8'h01, 1'b0, 1'b0, 8, 7};
    vecs[11] = '{SRL, 8'h80, 8'd8,  8'h00, 1'b1, 1'b0, 9, 8};
    vecs[12] = '{SLL, 8'h01, 8'd255, 8'h00, 1'b1, 1'b0, 9, 8};
    vecs[13] = '{ROR, 8'hA5, 8'd8,  8'hA5, 1'b0, 1'b0, 1, 0};
    vecs[14] = '{SRA, 8'h40, 8'd3,  8'h08, 1'b0, 1'b0, 4, 3};

    rst_n  = 1'b0;
    start  = 1'b0;
    select = FWD;
    data1  = 8'h00;
    data2  = 8'h00;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_done",   {31'd0, done},  32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_zero",   {31'd0, zero},  32'd1);
    check("rst_carry",  {31'd0, carry}, 32'd0);
    rst_n = 1'b1;

    // Table of vectors.
    for (int v = 0; v < 15; v++) begin
      run_op(vecs[v].sel, vecs[v].a, vecs[v].b, lat, nbusy);
      $display("vec %0d: sel=%0d a=%02h b=%02h -> result=%02h zero=%0d carry=%0d lat=%0d busy=%0d",
               v, vecs[v].sel, vecs[v].a, vecs[v].b, result, zero, carry, lat, nbusy);
      check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("v%0d_busy", v), nbusy, vecs[v].nbusy);
      check($sformatf("v%0d_result", v), {24'd0, result}, {24'd0, vecs[v].res});
      check($sformatf("v%0d_zero", v), {31'd0, zero}, {31'd0, vecs[v].z});
      check($sformatf("v%0d_carry", v), {31'd0, carry}, {31'd0, vecs[v].c});
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), {31'd0, done}, 32'd0);
    end

    // Back-to-back: AND then FWD with START held high.
    @(negedge clk);
    select = AND; data1 = 8'h0F; data2 = 8'hF0; start = 1'b1;
    @(negedge clk);
    check("b2b_and_done",   {31'd0, done},  32'd1);
    check("b2b_and_result", {24'd0, result}, 32'h00);
    check("b2b_and_zero",   {31'd0, zero},  32'd1);
    select = FWD; data2 = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    check("b2b_fwd_done",   {31'd0, done},  32'd1);
    check("b2b_fwd_result", {24'd0, result}, 32'h5A);
    check("b2b_fwd_busy",   {31'd0, busy},  32'd0);
    @(negedge clk);
    check("b2b_done_drop",  {31'd0, done},  32'd0);
    $display("b2b: AND then FWD -> result=%02h", result);

    // SLL 0x81 by 3 with operands and opcode changed mid-shift.
    select = SLL; data1 = 8'h81; data2 = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    select = ADD; data1 = 8'hFF; data2 = 8'h01;
    check("latch_busy1", {31'd0, busy}, 32'd1);
    ndone = 0;
    lat = MAX_WAIT + 1;
    for (int i = 2; i <= MAX_WAIT; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    check("latch_latency", lat, 4);
    check("latch_result", {24'd0, result}, 32'h08);
    check("latch_carry",  {31'd0, carry},  32'd0);
    $display("latch: SLL 81 by 3 with mid-shift changes -> result=%02h lat=%0d", result, lat);

    // ROR 0x01 by 10 with a START+ADD pulse while busy: exactly one DONE.
    @(negedge clk);
    select = ROR; data1 = 8'h01; data2 = 8'd10; start = 1'b1;
    @(negedge clk);
    select = ADD; data1 = 8'hF0; data2 = 8'h20;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    if (done) ndone++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignore_ndone",  ndone, 1);
    check("ignore_result", {24'd0, result}, 32'h40);
    check("ignore_carry",  {31'd0, carry},  32'd0);
    check("ignore_busy",   {31'd0, busy},   32'd0);
    $display("ignore: ROR 01 by 10 with START while busy -> result=%02h dones=%0d", result, ndone);

    // Reset asserted mid-shift (SLL by 7, reset during cycle t+3).
    select = SLL; data1 = 8'h03; data2 = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy",   {31'd0, busy},  32'd0);
    check("rstmid_result", {24'd0, result}, 32'd0);
    check("rstmid_zero",   {31'd0, zero},  32'd1);
    check("rstmid_done",   {31'd0, done},  32'd0);
    ndone = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rstmid_no_done", ndone, 0);
    $display("rstmid: reset during SLL -> result=%02h dones=%0d", result, ndone);

    run_op(ADD, 8'h01, 8'h01, lat, nbusy);
    check("post_rst_latency", lat, 1);
    check("post_rst_result", {24'd0, result}, 32'h02);
    check("post_rst_carry",  {31'd0, carry},  32'd0);
    $display("post_rst: ADD 01+01 -> result=%02h lat=%0d", result, lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
